// File: rtl/sum_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sum_arbiter_pkg
//  Description : Shared definitions for the time-shared adder arbiter:
//                default operand width / requester count and the FSM state
//                encoding used by sum_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package sum_arbiter_pkg;

    localparam int c_M_DEFAULT    = 4;
    localparam int c_NREQ_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : sum_arbiter_pkg
`default_nettype wire

// File: rtl/sum_arbiter_sum_N.sv
`default_nettype none
// ============================================================================
//  Module      : sum_N
//  Description : N-bit ripple-carry adder, no carry-in.
//  Ports       : a, b  - N-bit operands
//                y     - (a+b) mod 2^N
//                cout  - carry out of the MSB
//  Revision    : 1.0 - initial release
// ============================================================================
module sum_N #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y,
    output logic         cout
);

    logic [N:0] w_carry;

    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign y[i]         = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign cout = w_carry[N];

endmodule : sum_N
`default_nettype wire

// File: rtl/sum_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sum_arbiter
//  Description : Shares one M-bit adder among NREQ requesters. Round-robin
//                arbitration in IDLE, operand capture on the request
//                handshake, one CALC cycle, then the registered result is
//                presented to the owning requester until it accepts it.
//  Parameters  : M    - operand width (>= 2)
//                NREQ - number of requesters (2..8)
//  Ports       : clk, rst         - clock / synchronous active-high reset
//                req_valid/ready  - per-requester request handshake
//                req_a, req_b     - per-requester operands
//                rsp_valid/ready  - per-requester response handshake
//                rsp_y, rsp_cout  - registered sum and carry-out
//  Revision    : 1.0 - initial release
// ============================================================================
module sum_arbiter
    import sum_arbiter_pkg::*;
#(
    parameter int M    = c_M_DEFAULT,
    parameter int NREQ = c_NREQ_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ-1:0][M-1:0]  req_a,
    input  logic [NREQ-1:0][M-1:0]  req_b,
    output logic [NREQ-1:0]         rsp_valid,
    input  logic [NREQ-1:0]         rsp_ready,
    output logic [M-1:0]            rsp_y,
    output logic                    rsp_cout
);

    localparam int c_PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           r_state;
    state_t           w_next_state;
    logic [c_PW-1:0]  r_rr_ptr;
    logic [c_PW-1:0]  r_id;
    logic [M-1:0]     r_a;
    logic [M-1:0]     r_b;
    logic [c_PW-1:0]  w_scan;
    logic [c_PW-1:0]  w_grant_idx;
    logic             w_grant_found;
    logic             w_req_hs;
    logic             w_rsp_hs;
    logic [M-1:0]     w_sum;
    logic             w_cout;

    // Round-robin search: start at rr_ptr and wrap, first valid wins.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_scan        = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan = c_PW'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_grant_found && req_valid[w_scan]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_scan;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (r_state == IDLE && w_grant_found) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (r_state == RESP) begin
            rsp_valid[r_id] = 1'b1;
        end
    end

    // The granted requester always has req_valid set, so a grant in IDLE
    // is a handshake. Only the owner's rsp_ready completes the response.
    assign w_req_hs = (r_state == IDLE) && w_grant_found;
    assign w_rsp_hs = (r_state == RESP) && rsp_ready[r_id];

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_req_hs) w_next_state = CALC;
            CALC:    w_next_state = RESP;
            RESP:    if (w_rsp_hs) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    sum_N #(
        .N (M)
    ) u_sum (
        .a    (r_a),
        .b    (r_b),
        .y    (w_sum),
        .cout (w_cout)
    );

    // Capture, result and arbitration-pointer registers. The result is only
    // loaded in CALC, so it holds its last value everywhere else.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            rsp_y    <= '0;
            rsp_cout <= 1'b0;
        end else begin
            if (w_req_hs) begin
                r_a  <= req_a[w_grant_idx];
                r_b  <= req_b[w_grant_idx];
                r_id <= w_grant_idx;
            end
            if (r_state == CALC) begin
                rsp_y    <= w_sum;
                rsp_cout <= w_cout;
            end
            if (w_rsp_hs) begin
                r_rr_ptr <= (r_id == c_PW'(NREQ - 1)) ? '0 : r_id + c_PW'(1);
            end
        end
    end

endmodule : sum_arbiter
`default_nettype wire

// File: tb/tb_sum_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sum_arbiter
//  Description : Scoreboard bench for sum_arbiter (M=4, NREQ=2). Expected
//                results are queued at each request handshake and compared
//                when the response is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_arbiter;

    localparam int M    = 4;
    localparam int NREQ = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0][M-1:0] req_a;
    logic [NREQ-1:0][M-1:0] req_b;
    logic [NREQ-1:0]        rsp_valid;
    logic [NREQ-1:0]        rsp_ready;
    logic [M-1:0]           rsp_y;
    logic                   rsp_cout;

    always #5 clk = ~clk;

    sum_arbiter #(
        .M    (M),
        .NREQ (NREQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_cout  (rsp_cout)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int y;
        int c;
        int cyc;
    } exp_t;

    exp_t            q[$];
    logic [NREQ-1:0] prev_rv = '0;

    // Monitor: push on request handshake, compare on response handshake.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            prev_rv <= '0;
        end else begin
            check("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            check("rsp_valid_onehot0", 32'($onehot0(rsp_valid)), 32'd1);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    q.push_back('{i,
                                  (int'(req_a[i]) + int'(req_b[i])) % 16,
                                  (int'(req_a[i]) + int'(req_b[i])) / 16,
                                  cyc});
                end
            end
            if (rsp_valid != '0 && prev_rv == '0) begin
                if (q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    check("rsp_latency", 32'(cyc), 32'(q[0].cyc + 2));
                    check("rsp_route", 32'(rsp_valid), 32'(1 << q[0].id));
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    if (q.size() == 0) begin
                        check("rsp_unexpected", 32'd1, 32'd0);
                    end else begin
                        check("rsp_id", 32'(i), 32'(q[0].id));
                        check("rsp_y", 32'(rsp_y), 32'(q[0].y));
                        check("rsp_cout", 32'(rsp_cout), 32'(q[0].c));
                        void'(q.pop_front());
                    end
                end
            end
            prev_rv <= rsp_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for any request handshake; returns just after the accepting edge.
    task automatic wait_grant(output int idx);
        idx = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != '0) begin
                idx = req_ready[1] ? 1 : 0;
                break;
            end
        end
        if (idx < 0) check("grant_timeout", 32'd0, 32'd1);
        step();
    endtask

    // Returns at the negedge of the first cycle with rsp_valid[id] high.
    task automatic wait_rsp(input int id);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid[id]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input int id, input logic [3:0] a, input logic [3:0] b);
        int         g;
        logic [4:0] s;
        s             = {1'b0, a} + {1'b0, b};
        rsp_ready     = 2'b11;
        req_valid[id] = 1'b1;
        req_a[id]     = a;
        req_b[id]     = b;
        wait_grant(g);
        check("grant_id", 32'(g), 32'(id));
        req_valid[id] = 1'b0;
        wait_rsp(id);
        @(negedge clk);
        check("idle_after_rsp", 32'(rsp_valid), 32'd0);
        check("y_hold", 32'(rsp_y), 32'(s[3:0]));
        check("cout_hold", 32'(rsp_cout), 32'(s[4]));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int g;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '0;
        step();
        step();
        @(negedge clk);
        check("rst_rsp_y", 32'(rsp_y), 32'd0);
        check("rst_rsp_cout", 32'(rsp_cout), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Basic add and boundary values
        do_op(0, 4'd9,  4'd8);
        do_op(0, 4'd15, 4'd1);
        do_op(0, 4'd0,  4'd0);
        do_op(1, 4'd7,  4'd8);
        do_op(1, 4'd10, 4'd11);

        // Contention from reset: strict alternation 0,1,0,1
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req_a[0]  = 4'd3;
        req_b[0]  = 4'd4;
        req_a[1]  = 4'd12;
        req_b[1]  = 4'd5;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int j = 0; j < 4; j++) begin
            wait_grant(g);
            check("rr_order", 32'(g), 32'(j % 2));
        end
        req_valid = '0;
        wait_rsp(1);
        step();
        step();

        // Backpressure on req0; req1's rsp_ready must be ignored
        rsp_ready = 2'b10;
        req_valid = 2'b01;
        req_a[0]  = 4'd6;
        req_b[0]  = 4'd13;
        wait_grant(g);
        check("bp_grant", 32'(g), 32'd0);
        req_valid = 2'b10;
        req_a[1]  = 4'd1;
        req_b[1]  = 4'd2;
        wait_rsp(0);
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_y", 32'(rsp_y), 32'd3);
            check("bp_rsp_cout", 32'(rsp_cout), 32'd1);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            if (k < 4) @(negedge clk);
        end
        step();
        rsp_ready = 2'b11;
        wait_grant(g);
        check("bp_next_grant", 32'(g), 32'd1);
        req_valid = '0;
        wait_rsp(1);
        step();
        step();

        // Operands change right after the handshake
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        req_a[0]  = 4'd5;
        req_b[0]  = 4'd2;
        wait_grant(g);
        check("stab_grant", 32'(g), 32'd0);
        req_a[0]  = 4'd15;
        req_b[0]  = 4'd15;
        req_valid = '0;
        wait_rsp(0);
        step();
        step();

        // Reset while in RESP; rr_ptr is 1 beforehand
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        req_a[0]  = 4'd1;
        req_b[0]  = 4'd1;
        wait_grant(g);
        req_valid = '0;
        wait_rsp(0);
        step();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        @(negedge clk);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rsp_y", 32'(rsp_y), 32'd0);
        check("abort_rsp_cout", 32'(rsp_cout), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = '0;
        wait_rsp(0);
        step();
        step();
        step();

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_sum_arbiter
`default_nettype wire

// File: doc/sum_arbiter.md
SUM_ARBITER -- requirements
Module: sum_arbiter

Interface
REQ-001 Parameter M, default 4: operand width in bits; SHALL be at least 2.
REQ-002 Parameter NREQ, default 2: number of requesters; SHALL be 2 to 8.
REQ-003 Port clk, input, 1: single clock, rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port req_valid, input, NREQ: per-requester operation request.
REQ-006 Port req_ready, output, NREQ: per-requester acceptance; at most one bit high.
REQ-007 Port req_a, input, NREQ x M: per-requester operand A.
REQ-008 Port req_b, input, NREQ x M: per-requester operand B.
REQ-009 Port rsp_valid, output, NREQ: result valid; at most one bit high, routed to the owning requester.
REQ-010 Port rsp_ready, input, NREQ: per-requester result acceptance.
REQ-011 Port rsp_y, output, M: registered sum (A+B) mod 2^M.
REQ-012 Port rsp_cout, output, 1: registered carry-out of A+B.

Function
REQ-013 The block SHALL time-share one M-bit adder among NREQ requesters, one operation in flight at a time.
REQ-014 The FSM SHALL have states IDLE, CALC and RESP.
- IDLE -> CALC on a request handshake.
- CALC -> RESP unconditionally after one cycle.
- RESP -> IDLE on the response handshake.
REQ-015 In IDLE, req_ready SHALL be one-hot for the first requester with req_valid=1, searching upward from rr_ptr and wrapping. It SHALL be all-zero when no req_valid is set.
REQ-016 req_ready SHALL be a combinational function of req_valid, state and rr_ptr. It SHALL be all-zero in CALC and RESP.
REQ-017 A request handshake (req_valid[i] & req_ready[i]) SHALL capture req_a[i], req_b[i] and index i into internal registers.
REQ-018 In CALC, the adder result from the captured operands SHALL be registered into rsp_y/rsp_cout.
REQ-019 Sum and carry SHALL be exact.
- rsp_cout = 1 iff A+B >= 2^M.
- rsp_y = (A+B) mod 2^M.
- There is no carry-in.
REQ-020 In RESP, rsp_valid[id] SHALL be 1 for the captured index only.
REQ-021 In RESP, rsp_y, rsp_cout and rsp_valid SHALL hold stable until rsp_ready[id]=1.
REQ-022 rsp_ready bits of other requesters SHALL be ignored.
REQ-023 Latency: a handshake at edge t SHALL give rsp_valid high from edge t+2. Minimum occupancy SHALL be 3 cycles per operation.
REQ-024 On the response handshake, rr_ptr SHALL become (id+1) mod NREQ.
REQ-025 Simultaneous requests SHALL be served in round-robin order; no requester SHALL wait more than NREQ-1 operations.
REQ-026 A requester dropping req_valid before its handshake SHALL NOT be served.
REQ-027 Operand changes after the handshake SHALL NOT affect the result.
REQ-028 rsp_y and rsp_cout SHALL keep their last value outside RESP.

Reset
REQ-029 With rst=1 at a rising edge, the block SHALL enter IDLE, with rr_ptr=0, captured operands=0, rsp_y=0, rsp_cout=0, rsp_valid=0.
REQ-030 Reset in CALC or RESP SHALL abort the operation.
- No response SHALL be issued for the aborted operation.
- req_ready SHALL follow REQ-015 from the first cycle after reset.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, CALC, RESP) and the default values of M and NREQ.
REQ-032 The adder SHALL be one instance of the team's ripple-carry adder sum_N with its width parameter set to M.
REQ-033 Arbitration, capture and response registers SHALL reside in sum_arbiter.

Verification
REQ-034 Verification scenarios, M=4, NREQ=2:
- Basic add: req0 A=9, B=8, rsp_ready held 1 -> rsp_valid[0] two cycles after handshake, rsp_y=1, rsp_cout=1; back in IDLE one cycle later.
- Boundary values: A=15, B=1 -> y=0, cout=1. A=0, B=0 -> y=0, cout=0. A=7, B=8 -> y=15, cout=0.
- Contention: req0 and req1 both valid continuously after reset -> grant order 0,1,0,1. Each response goes only to the granted requester.
- Backpressure: rsp_ready[0]=0 for 5 cycles -> rsp_valid[0], y and cout stable. req1 sees req_ready=0 throughout.
- Operand stability: req0 changes A/B the cycle after handshake -> result still matches the captured operands.
- Reset mid-operation: rst pulsed in RESP -> rsp_valid=0, rsp_y=0, rr_ptr=0; the next pending request is granted from index 0.
